r_resp_arbiter: RTL and testbench
=================================

R_RESP_ARBITER -- requirements
Module: r_resp_arbiter

Interface
REQ-001 SHALL have parameter N_SRC, default 4, number of internal R-response sources (2..8).
REQ-002 SHALL have parameters ID_WIDTH=4, DATA_WIDTH=64, RESP_WIDTH=2, TAG_WIDTH=4, the AXI R field widths.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports src_valid and src_ready  input/output  N_SRC  per-source handshake, bit i = source i.
REQ-006 SHALL have ports src_id, src_data, src_resp, src_last and src_tagid  input  N_SRC x field width  per-source R beat, packed arrays.
REQ-007 SHALL have ports out_valid and out_ready  output/input  1  handshake toward the outgoing response buffer.
REQ-008 SHALL have ports out_id, out_data, out_resp, out_last and out_tagid  output  field width  registered R beat.
REQ-009 SHALL have port out_src  output  clog2(N_SRC)  index of the source that produced the current out beat.

Function
REQ-010 SHALL run a 2-state FSM: ARB (no burst owner) and BURST (owner held).
REQ-011 In ARB, SHALL grant the lowest index at or after rr_ptr whose src_valid=1 (round-robin), in the same cycle.
REQ-012 SHALL define load = !out_valid || out_ready; a source beat is accepted when src_valid[g] && src_ready[g].
REQ-013 SHALL drive src_ready[i] = load && (i == current grant); all other ready bits 0.
REQ-014 On acceptance, SHALL register the beat to the out_* ports and set out_valid=1 on the next edge; latency 1 cycle.
REQ-015 SHALL hold out_* stable while out_valid && !out_ready.
REQ-016 SHALL clear out_valid when out_ready=1 and no new beat is accepted that cycle.
REQ-017 An accepted beat with last=0 SHALL move the FSM ARB->BURST with owner = grant.
REQ-018 An accepted beat with last=1 SHALL return the FSM to ARB and set rr_ptr = (owner+1) mod N_SRC, wrapping at N_SRC-1 -> 0.
REQ-019 In BURST, SHALL ignore all other sources; owner src_valid=0 produces a bubble, not a re-arbitration.
REQ-020 Simultaneous out_ready and new acceptance SHALL replace the out register with no bubble, giving full throughput.
REQ-021 No src_valid asserted in ARB SHALL leave rr_ptr unchanged.

Reset
REQ-022 rst=0 SHALL asynchronously force FSM=ARB, rr_ptr=0, out_valid=0, out_src=0 and out_id/data/resp/last/tagid=0.
REQ-023 Reset mid-burst SHALL drop the partial burst; after release, arbitration restarts from source 0.

Configuration
REQ-024 Macro R_ARB_BURST_LOCK_EN defined SHALL select the behaviour in REQ-017..REQ-019 (grant locked until last).
REQ-025 With R_ARB_BURST_LOCK_EN undefined, SHALL stay in ARB permanently, re-arbitrate every beat, and advance rr_ptr after each accepted beat.
REQ-026 With R_ARB_BURST_LOCK_EN undefined, beats of different sources interleave; this is legal because sources carry distinct IDs.

Structure
REQ-027 Package rob_pkg SHALL hold the r_resp_t packed struct (id, data, resp, last, tagid) and the FSM state enum.
REQ-028 Round-robin selection SHALL live in sub-module rr_arbiter (inputs req vector and ptr; output one-hot grant and index), instantiated once.
REQ-029 The block SHALL contain no FIFO; buffering stays in the downstream outgoing response buffer.

Verification
REQ-030 A bench SHALL cover: reset release, all src_valid=0 -> out_valid=0, all src_ready=0, rr_ptr=0.
REQ-031 A bench SHALL cover: src0 and src2 each send a 1-beat response at once, out_ready=1 -> out_src 0 then 2 on consecutive cycles, no bubble.
REQ-032 A bench SHALL cover (lock enabled): src1 sends a 4-beat burst while src3 is valid -> four src1 beats with last only on the 4th, then src3 in the following cycle.
REQ-033 A bench SHALL cover: out_ready=0 for 3 cycles with out_valid=1 -> out_* stable, src_ready all 0, no beat lost or duplicated.
REQ-034 A bench SHALL cover: rr_ptr=N_SRC-1 with sources 0 and N_SRC-1 valid -> N_SRC-1 granted first, then 0 (wrap-around).
REQ-035 A bench SHALL cover: rst asserted after beat 2 of a 4-beat burst -> out_valid=0 immediately; after release, src0 is granted when it is valid.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types for the R-response arbiter: beat struct, FSM state, pointer helper.
// Beat field widths here are the defaults the arbiter parameters must match.
package rob_pkg;

    localparam int R_ID_W   = 4;
    localparam int R_DATA_W = 64;
    localparam int R_RESP_W = 2;
    localparam int R_TAG_W  = 4;

    typedef struct packed {
        logic [R_ID_W-1:0]   id;
        logic [R_DATA_W-1:0] data;
        logic [R_RESP_W-1:0] resp;
        logic                last;
        logic [R_TAG_W-1:0]  tagid;
    } r_resp_t;

    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Round-robin successor of a source index, wrapping n-1 -> 0.
    function automatic int rr_next(input int cur, input int n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/r_resp_arbiter_if.sv
// Handshake bundle between the internal R sources, the arbiter and the response buffer.
// slave = arbiter side, master = sources plus downstream buffer.
interface r_resp_arbiter_if #(
    parameter int N_SRC      = 4,
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int RESP_WIDTH = 2,
    parameter int TAG_WIDTH  = 4
);
    localparam int IDX_W = $clog2(N_SRC);

    logic [N_SRC-1:0]                 src_valid;
    logic [N_SRC-1:0]                 src_ready;
    logic [N_SRC-1:0][ID_WIDTH-1:0]   src_id;
    logic [N_SRC-1:0][DATA_WIDTH-1:0] src_data;
    logic [N_SRC-1:0][RESP_WIDTH-1:0] src_resp;
    logic [N_SRC-1:0]                 src_last;
    logic [N_SRC-1:0][TAG_WIDTH-1:0]  src_tagid;

    logic                  out_valid;
    logic                  out_ready;
    logic [ID_WIDTH-1:0]   out_id;
    logic [DATA_WIDTH-1:0] out_data;
    logic [RESP_WIDTH-1:0] out_resp;
    logic                  out_last;
    logic [TAG_WIDTH-1:0]  out_tagid;
    logic [IDX_W-1:0]      out_src;

    modport master (
        output src_valid, src_id, src_data, src_resp, src_last, src_tagid, out_ready,
        input  src_ready, out_valid, out_id, out_data, out_resp, out_last, out_tagid, out_src
    );

    modport slave (
        input  src_valid, src_id, src_data, src_resp, src_last, src_tagid, out_ready,
        output src_ready, out_valid, out_id, out_data, out_resp, out_last, out_tagid, out_src
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping past N_SRC-1.
// Zero latency; gnt is all-zero when nothing requests.
module rr_arbiter #(
    parameter int N_SRC = 4,
    parameter int IDX_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_SRC-1:0] gnt,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        int               c;
        logic             found;
        logic [IDX_W-1:0] ci;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        ci    = '0;
        for (int k = 0; k < N_SRC; k++) begin
            c = int'(ptr) + k;
            if (c >= N_SRC) c = c - N_SRC;
            ci = IDX_W'(c);
            if (!found && req[ci]) begin
                found   = 1'b1;
                gnt[ci] = 1'b1;
                idx     = ci;
            end
        end
    end

endmodule

// File: rtl/r_resp_arbiter.sv
// Round-robin merge of N_SRC internal R-beat sources into one registered R stream; R_ARB_BURST_LOCK_EN locks the grant until last.
// Latency: 1 cycle from source acceptance to out_valid; full throughput when out_ready stays high.
// Backpressure: out_valid && !out_ready holds out_* and drops every src_ready; no internal buffering.
module r_resp_arbiter
    import rob_pkg::*;
#(
    parameter int N_SRC      = 4,
    parameter int ID_WIDTH   = R_ID_W,
    parameter int DATA_WIDTH = R_DATA_W,
    parameter int RESP_WIDTH = R_RESP_W,
    parameter int TAG_WIDTH  = R_TAG_W
) (
    input  logic              clk,
    input  logic              rst,
    r_resp_arbiter_if.slave   bus
);

    localparam int IDX_W = $clog2(N_SRC);

    arb_state_e       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] out_src_q;
    logic             out_vld_q;
    r_resp_t          out_q;

    logic [N_SRC-1:0] arb_gnt;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_any;
    logic             load;
    logic [N_SRC-1:0] ready;
    logic             accept;
    logic [IDX_W-1:0] nxt_ptr;
    r_resp_t          sel;

    rr_arbiter #(.N_SRC(N_SRC), .IDX_W(IDX_W)) u_rr (
        .req (bus.src_valid),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    assign arb_any = |arb_gnt;

    // While a burst owns the output, the owner keeps the grant even when idle (bubble, no re-arbitration).
    assign grant_idx = (state == BURST) ? owner : arb_idx;
    assign grant_any = (state == BURST) || arb_any;
    assign load      = !out_vld_q || bus.out_ready;

    always_comb begin
        ready = '0;
        if (load && grant_any) ready[grant_idx] = 1'b1;
    end

    assign bus.src_ready = ready;
    assign accept        = bus.src_valid[grant_idx] && ready[grant_idx];
    assign nxt_ptr       = IDX_W'(rr_next(int'(grant_idx), N_SRC));

    always_comb begin
        sel       = '0;
        sel.id    = bus.src_id[grant_idx];
        sel.data  = bus.src_data[grant_idx];
        sel.resp  = bus.src_resp[grant_idx];
        sel.last  = bus.src_last[grant_idx];
        sel.tagid = bus.src_tagid[grant_idx];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ARB;
            rr_ptr    <= '0;
            owner     <= '0;
            out_vld_q <= 1'b0;
            out_src_q <= '0;
            out_q     <= '0;
        end else begin
            if (accept) begin
                out_q     <= sel;
                out_vld_q <= 1'b1;
                out_src_q <= grant_idx;
            end else if (bus.out_ready) begin
                out_vld_q <= 1'b0;
            end
`ifdef R_ARB_BURST_LOCK_EN
            if (accept) begin
                case (state)
                    ARB: begin
                        if (sel.last) begin
                            rr_ptr <= nxt_ptr;
                        end else begin
                            state <= BURST;
                            owner <= grant_idx;
                        end
                    end
                    BURST: begin
                        if (sel.last) begin
                            state  <= ARB;
                            rr_ptr <= nxt_ptr;
                        end
                    end
                    default: state <= ARB;
                endcase
            end
`else
            // Sources carry distinct IDs, so per-beat interleaving is legal.
            if (accept) rr_ptr <= nxt_ptr;
`endif
        end
    end

    assign bus.out_valid = out_vld_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_id    = out_q.id[ID_WIDTH-1:0];
    assign bus.out_data  = out_q.data[DATA_WIDTH-1:0];
    assign bus.out_resp  = out_q.resp[RESP_WIDTH-1:0];
    assign bus.out_last  = out_q.last;
    assign bus.out_tagid = out_q.tagid[TAG_WIDTH-1:0];

endmodule

// File: tb/tb_r_resp_arbiter.sv
// Directed table-driven bench for r_resp_arbiter (N_SRC=4) plus a hand-written mid-burst reset sequence.
// Expectations for the burst section follow the R_ARB_BURST_LOCK_EN build setting.
module tb_r_resp_arbiter;

    localparam int N = 4;

    logic clk;
    logic rst;

    r_resp_arbiter_if #(.N_SRC(N), .ID_WIDTH(4), .DATA_WIDTH(64), .RESP_WIDTH(2), .TAG_WIDTH(4)) bus ();

    r_resp_arbiter #(.N_SRC(N), .ID_WIDTH(4), .DATA_WIDTH(64), .RESP_WIDTH(2), .TAG_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0] vld;
        logic [3:0] lst;
        logic       ordy;
        logic [7:0] seq;
        logic [3:0] e_srdy;
        logic       e_ovld;
        logic [1:0] e_osrc;
        logic [7:0] e_oseq;
        logic       e_olast;
    } vec_t;

    vec_t tv[22];

    function automatic vec_t mk(input logic [3:0] vld, input logic [3:0] lst, input logic ordy,
                                input logic [7:0] seq, input logic [3:0] e_srdy, input logic e_ovld,
                                input logic [1:0] e_osrc, input logic [7:0] e_oseq, input logic e_olast);
        vec_t v;
        v.vld = vld; v.lst = lst; v.ordy = ordy; v.seq = seq;
        v.e_srdy = e_srdy; v.e_ovld = e_ovld; v.e_osrc = e_osrc; v.e_oseq = e_oseq; v.e_olast = e_olast;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s [%0d]: got 0x%0h, want 0x%0h", nm, idx, act, exp);
        end
    endtask

    // Each source s drives data = {seq, s}, id = s, resp = s, tagid = 15-s.
    task automatic drive(input logic [3:0] vld, input logic [3:0] lst, input logic ordy, input logic [7:0] seq);
        for (int s = 0; s < N; s++) begin
            bus.src_id[s]    = 4'(s);
            bus.src_data[s]  = {48'h0, seq, 8'(s)};
            bus.src_resp[s]  = 2'(s);
            bus.src_last[s]  = lst[s];
            bus.src_tagid[s] = 4'(15 - s);
        end
        bus.src_valid = vld;
        bus.out_ready = ordy;
    endtask

    task automatic chk_beat(input string nm, input int idx, input logic [1:0] src,
                            input logic [7:0] seq, input logic last);
        chk({nm, "_src"},   idx, 64'(bus.out_src),   64'(src));
        chk({nm, "_data"},  idx, bus.out_data,       {48'h0, seq, 6'h0, src});
        chk({nm, "_id"},    idx, 64'(bus.out_id),    64'({2'b00, src}));
        chk({nm, "_resp"},  idx, 64'(bus.out_resp),  64'(src));
        chk({nm, "_tagid"}, idx, 64'(bus.out_tagid), 64'(4'd15 - {2'b00, src}));
        chk({nm, "_last"},  idx, 64'(bus.out_last),  64'(last));
    endtask

    initial begin
        //            vld      lst      rdy  seq     srdy     ov   src    oseq   olast
        tv[0]  = mk(4'b0000, 4'b0000, 1'b1, 8'h00, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0);
        tv[1]  = mk(4'b0101, 4'b0101, 1'b1, 8'h01, 4'b0001, 1'b0, 2'd0, 8'h00, 1'b0);
        tv[2]  = mk(4'b0100, 4'b0100, 1'b1, 8'h02, 4'b0100, 1'b1, 2'd0, 8'h01, 1'b1);
        tv[3]  = mk(4'b0000, 4'b0000, 1'b1, 8'h00, 4'b0000, 1'b1, 2'd2, 8'h02, 1'b1);
        tv[4]  = mk(4'b0000, 4'b0000, 1'b1, 8'h00, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0);
        tv[5]  = mk(4'b1001, 4'b1001, 1'b1, 8'h05, 4'b1000, 1'b0, 2'd0, 8'h00, 1'b0);
        tv[6]  = mk(4'b0001, 4'b0001, 1'b1, 8'h06, 4'b0001, 1'b1, 2'd3, 8'h05, 1'b1);
        tv[7]  = mk(4'b0000, 4'b0000, 1'b1, 8'h00, 4'b0000, 1'b1, 2'd0, 8'h06, 1'b1);
        tv[8]  = mk(4'b0010, 4'b0010, 1'b0, 8'h08, 4'b0010, 1'b0, 2'd0, 8'h00, 1'b0);
        tv[9]  = mk(4'b0100, 4'b0100, 1'b0, 8'h09, 4'b0000, 1'b1, 2'd1, 8'h08, 1'b1);
        tv[10] = mk(4'b0100, 4'b0100, 1'b0, 8'h09, 4'b0000, 1'b1, 2'd1, 8'h08, 1'b1);
        tv[11] = mk(4'b0100, 4'b0100, 1'b0, 8'h09, 4'b0000, 1'b1, 2'd1, 8'h08, 1'b1);
        tv[12] = mk(4'b0100, 4'b0100, 1'b1, 8'h09, 4'b0100, 1'b1, 2'd1, 8'h08, 1'b1);
        tv[13] = mk(4'b0000, 4'b0000, 1'b1, 8'h00, 4'b0000, 1'b1, 2'd2, 8'h09, 1'b1);
        tv[14] = mk(4'b0000, 4'b0000, 1'b1, 8'h00, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0);
        tv[15] = mk(4'b0001, 4'b0001, 1'b1, 8'h0f, 4'b0001, 1'b0, 2'd0, 8'h00, 1'b0);
`ifdef R_ARB_BURST_LOCK_EN
        tv[16] = mk(4'b1010, 4'b1000, 1'b1, 8'h10, 4'b0010, 1'b1, 2'd0, 8'h0f, 1'b1);
        tv[17] = mk(4'b1010, 4'b1000, 1'b1, 8'h11, 4'b0010, 1'b1, 2'd1, 8'h10, 1'b0);
        tv[18] = mk(4'b1010, 4'b1000, 1'b1, 8'h12, 4'b0010, 1'b1, 2'd1, 8'h11, 1'b0);
        tv[19] = mk(4'b1010, 4'b1010, 1'b1, 8'h13, 4'b0010, 1'b1, 2'd1, 8'h12, 1'b0);
        tv[20] = mk(4'b1000, 4'b1000, 1'b1, 8'h14, 4'b1000, 1'b1, 2'd1, 8'h13, 1'b1);
        tv[21] = mk(4'b0000, 4'b0000, 1'b1, 8'h00, 4'b0000, 1'b1, 2'd3, 8'h14, 1'b1);
`else
        tv[16] = mk(4'b1010, 4'b1000, 1'b1, 8'h10, 4'b0010, 1'b1, 2'd0, 8'h0f, 1'b1);
        tv[17] = mk(4'b1010, 4'b1000, 1'b1, 8'h11, 4'b1000, 1'b1, 2'd1, 8'h10, 1'b0);
        tv[18] = mk(4'b0010, 4'b0000, 1'b1, 8'h12, 4'b0010, 1'b1, 2'd3, 8'h11, 1'b1);
        tv[19] = mk(4'b0010, 4'b0000, 1'b1, 8'h13, 4'b0010, 1'b1, 2'd1, 8'h12, 1'b0);
        tv[20] = mk(4'b0010, 4'b0010, 1'b1, 8'h14, 4'b0010, 1'b1, 2'd1, 8'h13, 1'b0);
        tv[21] = mk(4'b0000, 4'b0000, 1'b1, 8'h00, 4'b0000, 1'b1, 2'd1, 8'h14, 1'b1);
`endif

        rst = 1'b0;
        drive(4'b0000, 4'b0000, 1'b1, 8'h00);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 0, 64'(bus.out_valid), 64'd0);
        chk("rst_src_ready", 0, 64'(bus.src_ready), 64'd0);
        chk("rst_out_src",   0, 64'(bus.out_src),   64'd0);
        chk("rst_out_data",  0, bus.out_data,       64'd0);
        chk("rst_out_last",  0, 64'(bus.out_last),  64'd0);
        chk("rst_out_tagid", 0, 64'(bus.out_tagid), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            drive(tv[i].vld, tv[i].lst, tv[i].ordy, tv[i].seq);
            #1;
            chk("src_ready", i, 64'(bus.src_ready), 64'(tv[i].e_srdy));
            chk("out_valid", i, 64'(bus.out_valid), 64'(tv[i].e_ovld));
            if (tv[i].e_ovld) chk_beat("vec", i, tv[i].e_osrc, tv[i].e_oseq, tv[i].e_olast);
        end

        // Mid-burst reset: src2 sends two non-last beats, reset drops them, src0 wins afterwards.
        @(negedge clk);
        drive(4'b0100, 4'b0000, 1'b1, 8'h20);
        #1;
        chk("mrst_b1_ready", 0, 64'(bus.src_ready), 64'b0100);
        @(negedge clk);
        drive(4'b0100, 4'b0000, 1'b1, 8'h21);
        #1;
        chk("mrst_b2_ready", 1, 64'(bus.src_ready), 64'b0100);
        chk_beat("mrst_b1", 1, 2'd2, 8'h20, 1'b0);
        @(negedge clk);
        #1;
        chk("mrst_pre_valid", 2, 64'(bus.out_valid), 64'd1);
        chk_beat("mrst_b2", 2, 2'd2, 8'h21, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        chk("mrst_valid", 3, 64'(bus.out_valid), 64'd0);
        chk("mrst_data",  3, bus.out_data,       64'd0);
        chk("mrst_src",   3, 64'(bus.out_src),   64'd0);
        drive(4'b0101, 4'b0101, 1'b1, 8'h22);
        @(negedge clk);
        #1;
        chk("mrst_hold_valid", 4, 64'(bus.out_valid), 64'd0);
        rst = 1'b1;
        #1;
        chk("mrst_rel_ready", 4, 64'(bus.src_ready), 64'b0001);
        @(negedge clk);
        drive(4'b0000, 4'b0000, 1'b1, 8'h00);
        #1;
        chk("mrst_post_valid", 5, 64'(bus.out_valid), 64'd1);
        chk_beat("mrst_post", 5, 2'd0, 8'h22, 1'b1);
        @(negedge clk);
        #1;
        chk("mrst_drain_valid", 6, 64'(bus.out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
